// File: rtl/param_deserializer_fifo.sv
// rtl/param_deserializer_fifo.sv - serial-to-parallel word receiver with show-ahead FIFO (optional parity: DESER_PARITY_EN)
module param_deserializer_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk_100mhz,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       ack_in,
    input  logic                       flush_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_ready,
    output logic                       status_out,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       overflow_out,
    output logic                       parity_err_out
);

    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
`ifdef DESER_PARITY_EN
    localparam int FRAME  = WIDTH + 1;
`else
    localparam int FRAME  = WIDTH;
`endif
    localparam int CNT_W  = $clog2(FRAME);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [WIDTH-1:0]  sr_shift;
    logic [WIDTH-1:0]  word_in;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              ovf_q, ovf_d;
    logic              perr_q, perr_d;
    logic              accept;
    logic              last_bit;
    logic              push;
    logic              pop;
`ifdef DESER_PARITY_EN
    logic              par_ok;
    logic              par_edge;
`endif

    // Registered fill count drives the handshake and status outputs
    assign status_out     = (fill_q < FILL_W'(DEPTH));
    assign data_ready     = (fill_q != '0);
    assign fill_level     = fill_q;
    assign overflow_out   = ovf_q;
    assign parity_err_out = perr_q;
    assign data_out       = data_ready ? mem_q[rd_ptr_q] : '0;

    // Bit assembly, parity decision, push/pop and FIFO bookkeeping
    always_comb begin
        accept   = write_in && status_out && !flush_in;
        pop      = ack_in && data_ready && !flush_in;
        last_bit = accept && (cnt_q == CNT_W'(FRAME - 1));

        if (MSB_FIRST != 0) begin
            sr_shift = {sr_q[WIDTH-2:0], data_in};
        end else begin
            sr_shift = {data_in, sr_q[WIDTH-1:1]};
        end

`ifdef DESER_PARITY_EN
        // The trailing parity bit is checked but never shifted into the word
        par_edge = (cnt_q == CNT_W'(WIDTH));
        par_ok   = ~(^sr_q ^ data_in);
        word_in  = sr_q;
        push     = last_bit && par_ok;
        perr_d   = last_bit && !par_ok;
`else
        word_in  = sr_shift;
        push     = last_bit;
        perr_d   = 1'b0;
`endif

        cnt_d    = cnt_q;
        sr_d     = sr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;

        if (flush_in) begin
            cnt_d    = '0;
            sr_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (write_in && !status_out) begin
                ovf_d = 1'b1;
            end
            if (accept) begin
                cnt_d = last_bit ? '0 : cnt_q + CNT_W'(1);
`ifdef DESER_PARITY_EN
                if (!par_edge) begin
                    sr_d = sr_shift;
                end
`else
                sr_d = sr_shift;
`endif
            end
            if (push) begin
                mem_d[wr_ptr_q] = word_in;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                fill_d = fill_q + FILL_W'(1);
            end else if (pop && !push) begin
                fill_d = fill_q - FILL_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            sr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_param_deserializer_fifo.sv
// tb/tb_param_deserializer_fifo.sv - randomized self-checking bench for param_deserializer_fifo
module tb_param_deserializer_fifo;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 4;
    localparam int MSB_FIRST = 1;
`ifdef DESER_PARITY_EN
    localparam int FRAME     = WIDTH + 1;
`else
    localparam int FRAME     = WIDTH;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             d     = 1'b0;
    logic             w     = 1'b0;
    logic             a     = 1'b0;
    logic             f     = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             rdy;
    logic             st;
    logic [2:0]       fill;
    logic             ovf;
    logic             perr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] m_fifo[$];
    bit               m_bits[$];
    bit               m_ovf  = 1'b0;
    bit               m_perr = 1'b0;
    bit               chk_en = 1'b0;

    param_deserializer_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .MSB_FIRST(MSB_FIRST)
    ) dut (
        .clk_100mhz    (clk),
        .reset         (rst_n),
        .data_in       (d),
        .write_in      (w),
        .ack_in        (a),
        .flush_in      (f),
        .data_out      (dout),
        .data_ready    (rdy),
        .status_out    (st),
        .fill_level    (fill),
        .overflow_out  (ovf),
        .parity_err_out(perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_bits.delete();
        m_ovf  = 1'b0;
        m_perr = 1'b0;
    endtask

    // Word-level model: collect accepted bits, form a word per frame, queue it
    task automatic model_edge(input bit di, input bit wi, input bit ai, input bit fi);
        bit               can_take;
        bit               do_pop;
        bit               do_push;
        int               ones;
        logic [WIDTH-1:0] word;
        can_take = (m_fifo.size() < DEPTH);
        do_pop   = ai && (m_fifo.size() != 0);
        do_push  = 1'b0;
        ones     = 0;
        word     = '0;
        m_perr   = 1'b0;
        if (fi) begin
            m_fifo.delete();
            m_bits.delete();
            m_ovf = 1'b0;
            return;
        end
        if (wi && !can_take) m_ovf = 1'b1;
        if (wi && can_take) begin
            m_bits.push_back(di);
            if (m_bits.size() == FRAME) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (MSB_FIRST != 0) word[WIDTH-1-i] = m_bits[i];
                    else                word[i]         = m_bits[i];
                end
                foreach (m_bits[i]) ones += int'(m_bits[i]);
`ifdef DESER_PARITY_EN
                do_push = ((ones % 2) == 0);
`else
                do_push = 1'b1;
`endif
                m_perr = !do_push;
                m_bits.delete();
            end
        end
        if (do_pop)  void'(m_fifo.pop_front());
        if (do_push) m_fifo.push_back(word);
    endtask

    // Compare every DUT output against the model once per cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_out",   32'(dout), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'd0);
            chk("data_ready", 32'(rdy),  32'(m_fifo.size() != 0));
            chk("status_out", 32'(st),   32'(m_fifo.size() < DEPTH));
            chk("fill_level", 32'(fill), 32'(m_fifo.size()));
            chk("overflow",   32'(ovf),  32'(m_ovf));
            chk("parity_err", 32'(perr), 32'(m_perr));
        end
    end

    task automatic step(input bit di, input bit wi, input bit ai, input bit fi);
        d = di;
        w = wi;
        a = ai;
        f = fi;
        @(posedge clk);
        model_edge(di, wi, ai, fi);
        #1;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] word, input bit ack_last);
        bit bits[$];
        for (int i = 0; i < WIDTH; i++) bits.push_back(MSB_FIRST != 0 ? word[WIDTH-1-i] : word[i]);
`ifdef DESER_PARITY_EN
        bits.push_back(^word);
`endif
        foreach (bits[i]) step(bits[i], 1'b1, (i == bits.size() - 1) && ack_last, 1'b0);
    endtask

    logic [WIDTH-1:0] exp_words[4];

    initial begin
        model_reset();
        #2;
        chk("rst data_out",   32'(dout), 32'h0);
        chk("rst data_ready", 32'(rdy),  32'h0);
        chk("rst status_out", 32'(st),   32'h1);
        chk("rst fill_level", 32'(fill), 32'h0);
        chk("rst overflow",   32'(ovf),  32'h0);
        chk("rst parity_err", 32'(perr), 32'h0);
        #10;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Test 1: alternating bits form 8'h55
        send_frame(8'h55, 1'b0);
        chk("t1 data_ready", 32'(rdy),  32'h1);
        chk("t1 data_out",   32'(dout), 32'h55);
        chk("t1 fill_level", 32'(fill), 32'h1);

        // Test 2: pop the only word
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2 data_ready", 32'(rdy),  32'h0);
        chk("t2 data_out",   32'(dout), 32'h0);
        chk("t2 fill_level", 32'(fill), 32'h0);
        chk("t2 status_out", 32'(st),   32'h1);

        // Test 3: fill, refuse bits, drain in order, flush overflow
        exp_words[0] = 8'h11;
        exp_words[1] = 8'h22;
        exp_words[2] = 8'h33;
        exp_words[3] = 8'h44;
        for (int i = 0; i < 4; i++) send_frame(exp_words[i], 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3 status_out", 32'(st),   32'h0);
        chk("t3 overflow",   32'(ovf),  32'h1);
        chk("t3 fill_level", 32'(fill), 32'h4);
        for (int i = 0; i < 4; i++) begin
            chk("t3 drain order", 32'(dout), 32'(exp_words[i]));
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("t3 overflow kept", 32'(ovf), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3 flush overflow", 32'(ovf), 32'h0);

        // Test 4: last bit and pop on the same edge
        send_frame(8'h3C, 1'b0);
        send_frame(8'hC3, 1'b0);
        send_frame(8'h5A, 1'b1);
        chk("t4 fill_level", 32'(fill), 32'h2);
        chk("t4 head",       32'(dout), 32'hC3);

        // Test 5: async reset mid-word with FIFO non-empty
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5 data_ready", 32'(rdy),  32'h0);
        chk("t5 data_out",   32'(dout), 32'h0);
        chk("t5 fill_level", 32'(fill), 32'h0);
        chk("t5 status_out", 32'(st),   32'h1);
        chk("t5 overflow",   32'(ovf),  32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(8'hA5, 1'b0);
        chk("t5 word after reset", 32'(dout), 32'hA5);
        chk("t5 fill after reset", 32'(fill), 32'h1);

`ifdef DESER_PARITY_EN
        // Test 6: good and bad parity
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0);
        chk("t6 good parity fill", 32'(fill), 32'h1);
        for (int i = 0; i < WIDTH; i++) step(1'(i % 2), 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6 bad parity fill",  32'(fill), 32'h1);
        chk("t6 parity pulse",     32'(perr), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6 parity pulse end", 32'(perr), 32'h0);
`endif

        // Random traffic: write-heavy phase, then drain-heavy phase
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 99) < 80,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 2);
        end
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 2);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
